// File: rtl/surf_cmd_pkg.sv
// rtl/surf_cmd_pkg.sv - shared constants, state encoding and frame check for the SURF command receiver
//
// Purpose: command codes, frame geometry, FSM state type and the frame
// validity helper used by surf_cmd_receiver.
// Ports: none (package).

package surf_cmd_pkg;

  localparam int FRAME_BITS = 15;  // start + 12 data + parity + stop
  localparam int DATA_BITS  = 12;

  localparam logic [1:0] CMD_TRIG  = 2'b00;
  localparam logic [1:0] CMD_CLEAR = 2'b01;
  localparam logic [1:0] CMD_EVRST = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_PARITY = 2'd2,
    ST_STOP   = 2'd3
  } state_t;

  // A frame is good when data plus parity carry an odd number of ones
  // and the stop bit is low.
  function automatic logic frame_ok(input logic [DATA_BITS-1:0] d,
                                    input logic                 p,
                                    input logic                 stop);
    return (^{d, p}) & ~stop;
  endfunction

endpackage

// File: rtl/cmd_sync.sv
// rtl/cmd_sync.sv - multi-flop synchronizer for the serial CMD line
//
// Purpose: brings the TURF command line into the CLK125 domain.
// Ports:
//   i_clk    - CLK125
//   i_rst_n  - synchronous active-low reset, clears every stage
//   i_d      - raw serial input
//   o_q      - synchronized output (last stage)

module cmd_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_d,
  output logic o_q
);

  logic [SYNC_STAGES-1:0] r_sync;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_d};
    end
  end

  assign o_q = r_sync[SYNC_STAGES-1];

endmodule

// File: rtl/surf_cmd_receiver.sv
// rtl/surf_cmd_receiver.sv - serial command frame receiver and decoder for the SURF
//
// Purpose: deframes 15-bit commands from the TURF, checks parity/stop,
// decodes trigger / clear / event-counter reset, tracks buffer holds
// and the local event counter.
// Ports:
//   CLK125       - only clock
//   RST_N        - synchronous active-low reset
//   CMD          - serial command line (idles low)
//   TRIG         - one-cycle strobe, valid trigger
//   TRIG_BUF     - buffer of last trigger (held)
//   TRIG_EVNUM   - event number of last trigger (held)
//   CLEAR        - one-cycle strobe, valid clear
//   EVRST        - one-cycle strobe, event-counter reset
//   HOLD         - per-buffer hold state
//   EV_MISMATCH  - strobe with TRIG when EVNUM differs from local count
//   HOLD_OVERLAP - strobe with TRIG when the buffer was already held
//   FRAME_ERR    - strobe on parity or stop-bit error
//   ERR_CNT      - saturating count of frame errors

module surf_cmd_receiver
  import surf_cmd_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic       CLK125,
  input  logic       RST_N,
  input  logic       CMD,
  output logic       TRIG,
  output logic [1:0] TRIG_BUF,
  output logic [7:0] TRIG_EVNUM,
  output logic       CLEAR,
  output logic       EVRST,
  output logic [3:0] HOLD,
  output logic       EV_MISMATCH,
  output logic       HOLD_OVERLAP,
  output logic       FRAME_ERR,
  output logic [7:0] ERR_CNT
);

  logic                 w_bit;
  state_t               r_state;
  state_t               w_state_next;
  logic                 w_shift_en;
  logic                 w_frame_done;
  logic [3:0]           r_bit_cnt;
  logic [DATA_BITS-1:0] r_shift;
  logic                 r_par;

  logic [1:0]           w_code;
  logic [1:0]           w_buf;
  logic [7:0]           w_evnum;

  logic                 r_trig;
  logic                 r_clear;
  logic                 r_evrst;
  logic                 r_mis;
  logic                 r_ovl;
  logic                 r_ferr;
  logic [1:0]           r_trig_buf;
  logic [7:0]           r_trig_evnum;
  logic [3:0]           r_hold;
  logic [7:0]           r_evcnt;
  logic [7:0]           r_err_cnt;

  cmd_sync #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync (
    .i_clk   (CLK125),
    .i_rst_n (RST_N),
    .i_d     (CMD),
    .o_q     (w_bit)
  );

  // FSM state register
  always_ff @(posedge CLK125) begin
    if (!RST_N) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // FSM next state; IDLE treats any synced 1 as a start bit
  always_comb begin
    w_state_next = r_state;
    w_shift_en   = 1'b0;
    w_frame_done = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_bit) w_state_next = ST_SHIFT;
      end
      ST_SHIFT: begin
        w_shift_en = 1'b1;
        if (r_bit_cnt == 4'(DATA_BITS - 1)) w_state_next = ST_PARITY;
      end
      ST_PARITY: begin
        w_state_next = ST_STOP;
      end
      ST_STOP: begin
        w_frame_done = 1'b1;
        w_state_next = ST_IDLE;
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  // Data bits arrive MSB first, so shift left
  always_ff @(posedge CLK125) begin
    if (!RST_N) begin
      r_bit_cnt <= '0;
      r_shift   <= '0;
      r_par     <= 1'b0;
    end else begin
      if (r_state == ST_IDLE) r_bit_cnt <= '0;
      if (w_shift_en) begin
        r_shift   <= {r_shift[DATA_BITS-2:0], w_bit};
        r_bit_cnt <= r_bit_cnt + 4'd1;
      end
      if (r_state == ST_PARITY) r_par <= w_bit;
    end
  end

  assign w_code  = r_shift[11:10];
  assign w_buf   = r_shift[9:8];
  assign w_evnum = r_shift[7:0];

  // Decode at the stop-bit sample; w_bit is the stop bit on that edge.
  // Strobes default low every cycle, and a frame completes at most once
  // per 15 cycles, so no strobe can stretch past one cycle.
  always_ff @(posedge CLK125) begin
    if (!RST_N) begin
      r_trig       <= 1'b0;
      r_clear      <= 1'b0;
      r_evrst      <= 1'b0;
      r_mis        <= 1'b0;
      r_ovl        <= 1'b0;
      r_ferr       <= 1'b0;
      r_trig_buf   <= '0;
      r_trig_evnum <= '0;
      r_hold       <= '0;
      r_evcnt      <= '0;
      r_err_cnt    <= '0;
    end else begin
      r_trig  <= 1'b0;
      r_clear <= 1'b0;
      r_evrst <= 1'b0;
      r_mis   <= 1'b0;
      r_ovl   <= 1'b0;
      r_ferr  <= 1'b0;
      if (w_frame_done) begin
        if (!frame_ok(r_shift, r_par, w_bit)) begin
          r_ferr <= 1'b1;
          if (r_err_cnt != 8'hFF) r_err_cnt <= r_err_cnt + 8'd1;
        end else begin
          case (w_code)
            CMD_TRIG: begin
              r_trig       <= 1'b1;
              r_trig_buf   <= w_buf;
              r_trig_evnum <= w_evnum;
              r_mis        <= (w_evnum != r_evcnt);
              r_evcnt      <= w_evnum + 8'd1;
              if (r_hold[w_buf]) r_ovl <= 1'b1;
              else               r_hold[w_buf] <= 1'b1;
            end
            CMD_CLEAR: begin
              r_clear       <= 1'b1;
              r_hold[w_buf] <= 1'b0;
            end
            CMD_EVRST: begin
              r_evrst <= 1'b1;
              r_evcnt <= 8'd0;
            end
            default: begin
              // reserved code: accepted silently
            end
          endcase
        end
      end
    end
  end

  assign TRIG         = r_trig;
  assign TRIG_BUF     = r_trig_buf;
  assign TRIG_EVNUM   = r_trig_evnum;
  assign CLEAR        = r_clear;
  assign EVRST        = r_evrst;
  assign HOLD         = r_hold;
  assign EV_MISMATCH  = r_mis;
  assign HOLD_OVERLAP = r_ovl;
  assign FRAME_ERR    = r_ferr;
  assign ERR_CNT      = r_err_cnt;

endmodule

// File: tb/tb_surf_cmd_receiver.sv
// tb/tb_surf_cmd_receiver.sv - self-checking bench for surf_cmd_receiver

module tb_surf_cmd_receiver;

  logic       CLK125 = 1'b0;
  logic       RST_N  = 1'b0;
  logic       CMD    = 1'b0;
  logic       TRIG, CLEAR, EVRST, EV_MISMATCH, HOLD_OVERLAP, FRAME_ERR;
  logic [1:0] TRIG_BUF;
  logic [7:0] TRIG_EVNUM, ERR_CNT;
  logic [3:0] HOLD;

  surf_cmd_receiver #(.SYNC_STAGES(2)) dut (
    .CLK125       (CLK125),
    .RST_N        (RST_N),
    .CMD          (CMD),
    .TRIG         (TRIG),
    .TRIG_BUF     (TRIG_BUF),
    .TRIG_EVNUM   (TRIG_EVNUM),
    .CLEAR        (CLEAR),
    .EVRST        (EVRST),
    .HOLD         (HOLD),
    .EV_MISMATCH  (EV_MISMATCH),
    .HOLD_OVERLAP (HOLD_OVERLAP),
    .FRAME_ERR    (FRAME_ERR),
    .ERR_CNT      (ERR_CNT)
  );

  always #5 CLK125 = ~CLK125;

  int cyc   = 0;
  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  always @(posedge CLK125) cyc++;

  // expected outcome of one frame: strobes {TRIG,CLEAR,EVRST,MIS,OVL,FERR}
  // and held outputs {TRIG_BUF,TRIG_EVNUM,HOLD,ERR_CNT} from that cycle on
  typedef struct {
    int          cyc;
    logic [5:0]  strb;
    logic [21:0] held;
  } ev_t;

  ev_t         evq[$];
  logic [21:0] cur_held = '0;

  // transaction-level reference state
  logic [3:0]  m_hold  = '0;
  logic [7:0]  m_evcnt = '0;
  logic [1:0]  m_buf   = '0;
  logic [7:0]  m_evnum = '0;
  int          m_err   = 0;

  int trig_seen_cyc  = -1;
  int clear_seen_cyc = -1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  always @(negedge CLK125) begin : p_chk
    logic [5:0] exp_strb;
    if (TRIG)  trig_seen_cyc  = cyc;
    if (CLEAR) clear_seen_cyc = cyc;
    if (chk_en) begin
      exp_strb = '0;
      if (evq.size() > 0 && evq[0].cyc == cyc) begin
        exp_strb = evq[0].strb;
        cur_held = evq[0].held;
        void'(evq.pop_front());
      end
      check("strobes", 32'({TRIG, CLEAR, EVRST, EV_MISMATCH, HOLD_OVERLAP, FRAME_ERR}), 32'(exp_strb));
      check("held", 32'({TRIG_BUF, TRIG_EVNUM, HOLD, ERR_CNT}), 32'(cur_held));
    end
  end

  function automatic logic [11:0] mk(input int code, input int b, input int ev);
    logic [11:0] d;
    d = {2'(code), 2'(b), 8'(ev)};
    return d;
  endfunction

  task automatic model_reset();
    evq.delete();
    cur_held = '0;
    m_hold = '0; m_evcnt = '0; m_buf = '0; m_evnum = '0; m_err = 0;
  endtask

  task automatic model_frame(input logic [11:0] d, input bit err, input int ecyc);
    ev_t e;
    int  b;
    e.cyc  = ecyc;
    e.strb = '0;
    b = int'(d[9:8]);
    if (err) begin
      e.strb[0] = 1'b1;
      if (m_err < 255) m_err++;
    end else begin
      case (int'(d[11:10]))
        0: begin
          e.strb[5] = 1'b1;
          e.strb[2] = (d[7:0] != m_evcnt);
          m_evcnt   = 8'((int'(d[7:0]) + 1) % 256);
          if (m_hold[b]) e.strb[1] = 1'b1;
          m_hold[b] = 1'b1;
          m_buf     = d[9:8];
          m_evnum   = d[7:0];
        end
        1: begin
          e.strb[4] = 1'b1;
          m_hold[b] = 1'b0;
        end
        2: begin
          e.strb[3] = 1'b1;
          m_evcnt   = 8'd0;
        end
        default: ;
      endcase
    end
    e.held = {m_buf, m_evnum, m_hold, 8'(m_err)};
    evq.push_back(e);
  endtask

  // rst_at >= 0 pulses RST_N alongside that frame bit and abandons the frame
  task automatic send_frame(input logic [11:0] d, input bit bad_par, input bit bad_stop,
                            input int rst_at);
    logic [14:0] f;
    logic        p;
    p = (($countones(d) % 2) == 0);
    if (bad_par) p = ~p;
    f = {1'b1, d, p, bad_stop};
    for (int i = 0; i < 15; i++) begin
      @(posedge CLK125); #1;
      if (i == 0) model_frame(d, bad_par || bad_stop, cyc + 17);
      CMD = f[14-i];
      if (i == rst_at) begin
        RST_N = 1'b0;
        @(posedge CLK125); #1;
        RST_N = 1'b1;
        CMD   = 1'b0;
        model_reset();
        return;
      end
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge CLK125); #1;
      CMD = 1'b0;
    end
  endtask

  task automatic do_reset();
    @(posedge CLK125); #1;
    RST_N = 1'b0;
    @(posedge CLK125); #1;
    RST_N = 1'b1;
    model_reset();
  endtask

  initial begin
    repeat (2) @(posedge CLK125);
    #1;
    chk_en = 1'b1;  // reset still asserted: all outputs must read zero
    idle(2);
    RST_N = 1'b1;
    idle(3);

    // trigger D=0x0A5 after reset
    send_frame(mk(0, 0, 8'hA5), 0, 0, -1);
    idle(20);
    @(negedge CLK125);
    check("t1_hold", 32'(HOLD), 32'h1);
    check("t1_evnum", 32'(TRIG_EVNUM), 32'hA5);
    // local count should now be 0xA6: no mismatch expected
    send_frame(mk(0, 1, 8'hA6), 0, 0, -1);
    idle(20);

    // evrst, trigger buf2 ev0, trigger buf2 ev1
    do_reset();
    send_frame(mk(2, 0, 0), 0, 0, -1);
    send_frame(mk(0, 2, 0), 0, 0, -1);
    idle(3);
    send_frame(mk(0, 2, 1), 0, 0, -1);
    idle(20);
    @(negedge CLK125);
    check("t2_hold", 32'(HOLD), 32'h4);

    // trigger buf3 then clear buf2 back-to-back
    do_reset();
    send_frame(mk(0, 3, 0), 0, 0, -1);
    send_frame(mk(1, 2, 0), 0, 0, -1);
    idle(20);
    @(negedge CLK125);
    check("t3_gap", 32'(clear_seen_cyc - trig_seen_cyc), 32'd15);
    check("t3_hold", 32'(HOLD), 32'h8);

    // bad parity, then bad stop bit
    send_frame(mk(0, 0, 8'h11), 1, 0, -1);
    send_frame(mk(1, 3, 0), 0, 1, -1);
    idle(20);
    @(negedge CLK125);
    check("t4_errcnt", 32'(ERR_CNT), 32'd2);
    check("t4_hold", 32'(HOLD), 32'h8);
    // count must still be 1 after the earlier ev0 trigger
    send_frame(mk(0, 0, 1), 0, 0, -1);
    idle(20);

    // reset in the middle of a trigger frame, then a clean trigger
    send_frame(mk(0, 1, 8'h33), 0, 0, 6);
    idle(20);
    send_frame(mk(0, 1, 0), 0, 0, -1);
    idle(20);
    @(negedge CLK125);
    check("t5_hold", 32'(HOLD), 32'h2);
    check("t5_errcnt", 32'(ERR_CNT), 32'd0);

    // randomized traffic: mixed commands, errors, gaps including none
    for (int k = 0; k < 150; k++) begin
      int  r;
      bit  bp, bs;
      r  = int'($urandom_range(0, 19));
      bp = (r == 0);
      bs = (r == 1);
      send_frame(mk(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                    ($urandom_range(0, 1) == 0) ? int'(m_evcnt) : int'($urandom_range(0, 255))),
                 bp, bs, -1);
      if ($urandom_range(0, 2) != 0) idle(int'($urandom_range(1, 3)));
    end
    idle(20);

    // 300 bad-parity frames: counter must stop at 255
    do_reset();
    for (int k = 0; k < 300; k++) begin
      send_frame(12'($urandom_range(0, 4095)), 1, 0, -1);
    end
    idle(20);
    @(negedge CLK125);
    check("t6_errcnt", 32'(ERR_CNT), 32'd255);
    check("drain", 32'(evq.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/surf_cmd_receiver.md
SURF_CMD_RECEIVER -- requirements
Module: surf_cmd_receiver

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2, meaning the number of synchronizer flops on CMD (minimum 2).
REQ-002 SHALL have port CLK125, input, 1, SURF clock forwarded by the TURF; the block's only clock.
REQ-003 SHALL have port RST_N, input, 1, reset that is synchronous to CLK125 and active-low.
REQ-004 SHALL have port CMD, input, 1, serial command line from the TURF; idles low.
REQ-005 SHALL have port TRIG, output, 1, one-cycle strobe for a valid trigger command.
REQ-006 SHALL have port TRIG_BUF, output, 2, buffer index of the last trigger; held until the next trigger.
REQ-007 SHALL have port TRIG_EVNUM, output, 8, event number of the last trigger; held until the next trigger.
REQ-008 SHALL have port CLEAR, output, 1, one-cycle strobe for a valid clear command.
REQ-009 SHALL have port EVRST, output, 1, one-cycle strobe for a valid event-counter reset command.
REQ-010 SHALL have port HOLD, output, 4, per-buffer hold state.
REQ-011 SHALL have port EV_MISMATCH, output, 1, one-cycle strobe: trigger event number differs from the local count.
REQ-012 SHALL have port HOLD_OVERLAP, output, 1, one-cycle strobe: trigger targets a buffer already held.
REQ-013 SHALL have port FRAME_ERR, output, 1, one-cycle strobe for a parity or stop-bit error.
REQ-014 SHALL have port ERR_CNT, output, 8, saturating count of FRAME_ERR events.

Function
REQ-015 Frame format SHALL be 15 bits, one bit per CLK125 cycle, with no mandatory idle gap between frames:
- start bit = 1
- 12 data bits, D[11] first
- odd parity over D[11:0]
- stop bit = 0
REQ-016 D[11:10] SHALL be decoded as follows:
- 00 = trigger: BUF = D[9:8], EVNUM = D[7:0]
- 01 = clear: BUF = D[9:8]
- 10 = event-counter reset
- 11 = reserved; accepted, no action, no error
REQ-017 CMD SHALL pass through a SYNC_STAGES-flop synchronizer; the FSM samples only the synchronized bit.
REQ-018 FSM states SHALL be IDLE, SHIFT, PARITY and STOP, with these transitions:
- IDLE -> SHIFT when the synced bit = 1
- SHIFT -> PARITY after 12 bits, counted by a 4-bit counter
- PARITY -> STOP after one cycle
- STOP -> IDLE after one cycle
REQ-019 Output latency SHALL be fixed: strobes and updated held outputs are registered at the STOP sampling edge.
- With SYNC_STAGES=2, the strobe is high during the cycle after the 16th edge following the edge that first captures the start bit.
REQ-020 A start bit arriving in the cycle immediately after a stop bit SHALL be accepted (back-to-back frames).
REQ-021 A parity mismatch or stop bit = 1 SHALL pulse FRAME_ERR and increment ERR_CNT (saturating at 255), with no command action and no other strobe.
REQ-022 The block SHALL keep an internal 8-bit event counter, EVCNT, with these rules:
- On a valid trigger, EV_MISMATCH pulses if EVNUM != EVCNT.
- On a valid trigger, EVCNT becomes EVNUM+1 (wraps 255 -> 0).
- On EVRST, EVCNT becomes 0.
REQ-023 On a valid trigger, HOLD[BUF] SHALL be set; HOLD_OVERLAP pulses if HOLD[BUF] was already set, and HOLD is unchanged in that case.
REQ-024 On a valid clear, HOLD[BUF] SHALL be cleared; clearing an unheld buffer is a no-op with no error.
REQ-025 At most one strobe of TRIG/CLEAR/EVRST/FRAME_ERR SHALL be asserted per cycle; EV_MISMATCH and HOLD_OVERLAP may accompany TRIG only.
REQ-026 Strobes SHALL never assert for longer than one cycle, including with back-to-back frames.

Reset
REQ-027 With RST_N low at a CLK125 edge, the FSM SHALL go to IDLE, the synchronizer flops to 0, and the bit counter and shift register to 0.
REQ-028 Under reset, all strobes SHALL be 0; HOLD, TRIG_BUF, TRIG_EVNUM, EVCNT and ERR_CNT SHALL be 0.
REQ-029 Reset asserted mid-frame SHALL discard the partial frame with no strobe; a frame whose start bit is synchronized after RST_N returns high SHALL decode normally.

Structure
REQ-030 A shared package surf_cmd_pkg SHALL hold:
- the command codes (CMD_TRIG=2'b00, CMD_CLEAR=2'b01, CMD_EVRST=2'b10)
- FRAME_BITS=15 and DATA_BITS=12
- the FSM state encoding
REQ-031 The synchronizer SHALL be one sub-module, cmd_sync, parameterized by SYNC_STAGES; the decode logic stays in surf_cmd_receiver.

Verification
REQ-032 Trigger frame with D=0x0A5, correct parity, after reset -> TRIG=1 for one cycle at the REQ-019 latency; TRIG_BUF=0; TRIG_EVNUM=0xA5; EV_MISMATCH=1 (EVCNT was 0); HOLD=4'b0001; EVCNT=0xA6.
REQ-033 EVRST frame, then trigger with BUF=2 and EVNUM=0, then trigger with BUF=2 and EVNUM=1 -> EVRST strobe; first TRIG with HOLD=4'b0100 and no mismatch; second TRIG with HOLD_OVERLAP=1 and no mismatch.
REQ-034 Clear frame with BUF=2 sent back-to-back after a trigger with BUF=3, no idle cycle -> TRIG then CLEAR exactly 15 cycles apart; HOLD=4'b1000.
REQ-035 Bad parity frame, then a stop bit = 1 frame -> two FRAME_ERR pulses; ERR_CNT=2; HOLD and EVCNT unchanged; no TRIG, CLEAR or EVRST.
REQ-036 RST_N low for one cycle at data bit 6 of a trigger, then a clean trigger with EVNUM=0 -> no strobe for the first frame; the second yields TRIG without mismatch and HOLD bit set.
REQ-037 A bench SHALL drive 300 frames with bad parity -> ERR_CNT saturates at 255 and does not wrap.
